// File: rtl/mips_mc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mc_ctrl_if
//  Description : Control/status bundle between the multi-cycle MIPS control
//                FSM (master) and the datapath/memory side (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_mc_ctrl_if;
  // Sequencing and datapath status into the controller
  logic        run;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ack;
  // Memory control
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel;
  // Datapath write enables and selects
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        link_write;
  logic [1:0]  pc_src;
  logic [1:0]  alu_op;
  logic        alu_src_imm;
  logic        wb_sel_mem;
  // Status
  logic        illegal;
  logic [15:0] instr_count;
  logic        busy;

  modport master (
    input  run, opcode, funct, zero, mem_ack,
    output mem_req, mem_we, mem_sel, ir_write, pc_write, reg_write, link_write,
           pc_src, alu_op, alu_src_imm, wb_sel_mem, illegal, instr_count, busy
  );

  modport slave (
    output run, opcode, funct, zero, mem_ack,
    input  mem_req, mem_we, mem_sel, ir_write, pc_write, reg_write, link_write,
           pc_src, alu_op, alu_src_imm, wb_sel_mem, illegal, instr_count, busy
  );
endinterface
`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mc_ctrl
//  Description : Multi-cycle MIPS control FSM. Sequences fetch, decode,
//                execute, memory and write-back for a small instruction
//                subset, counts retired instructions, flags bad opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  mips_mc_ctrl_if.master bus
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_BRANCH = 4'd6;
  localparam logic [3:0] S_JUMP   = 4'd7;
  localparam logic [3:0] S_MEM_RD = 4'd8;
  localparam logic [3:0] S_MEM_WR = 4'd9;
  localparam logic [3:0] S_WB_R   = 4'd10;
  localparam logic [3:0] S_WB_I   = 4'd11;
  localparam logic [3:0] S_WB_MEM = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  logic [3:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        illegal_q, illegal_d;
  logic        retire;

  logic        mem_req_w, mem_we_w, mem_sel_w;
  logic        ir_write_w, pc_write_w, reg_write_w, link_write_w;
  logic [1:0]  pc_src_w, alu_op_w;
  logic        alu_src_imm_w, wb_sel_mem_w;

  // Next-state, retire accounting and sticky illegal-opcode detection
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_ADDI:       state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J, OP_JAL:  state_d = S_JUMP;
          default: begin
            // Unsupported opcode: abandon without retiring
            illegal_d = 1'b1;
            state_d   = bus.run ? S_FETCH : S_IDLE;
          end
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_ADDR:   state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (bus.mem_ack) state_d = S_WB_MEM;
      S_MEM_WR: if (bus.mem_ack) retire = 1'b1;
      S_BRANCH, S_JUMP, S_WB_R, S_WB_I, S_WB_MEM: retire = 1'b1;
      default:  state_d = S_IDLE;
    endcase
    // run is only honoured at an instruction boundary
    if (retire) begin
      count_d = count_q + 16'd1;
      state_d = bus.run ? S_FETCH : S_IDLE;
    end
  end

  // State, counter and illegal flag registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= 16'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Control outputs decoded from the current state; only the ack cycle of
  // FETCH, the branch condition and the jal link depend on live inputs
  always_comb begin
    mem_req_w     = 1'b0;
    mem_we_w      = 1'b0;
    mem_sel_w     = 1'b0;
    ir_write_w    = 1'b0;
    pc_write_w    = 1'b0;
    reg_write_w   = 1'b0;
    link_write_w  = 1'b0;
    pc_src_w      = 2'd0;
    alu_op_w      = 2'd0;
    alu_src_imm_w = 1'b0;
    wb_sel_mem_w  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_w  = 1'b1;
        ir_write_w = bus.mem_ack;
        pc_write_w = bus.mem_ack;
      end
      S_EXEC_R: alu_op_w = 2'd2;
      S_EXEC_I, S_ADDR: alu_src_imm_w = 1'b1;
      S_MEM_RD: begin
        mem_req_w = 1'b1;
        mem_sel_w = 1'b1;
      end
      S_MEM_WR: begin
        mem_req_w = 1'b1;
        mem_sel_w = 1'b1;
        mem_we_w  = 1'b1;
      end
      S_BRANCH: begin
        alu_op_w   = 2'd1;
        pc_src_w   = 2'd1;
        pc_write_w = bus.zero;
      end
      S_JUMP: begin
        pc_write_w   = 1'b1;
        pc_src_w     = 2'd2;
        link_write_w = (bus.opcode == OP_JAL);
      end
      S_WB_R, S_WB_I: reg_write_w = 1'b1;
      S_WB_MEM: begin
        reg_write_w  = 1'b1;
        wb_sel_mem_w = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mem_req     = mem_req_w;
  assign bus.mem_we      = mem_we_w;
  assign bus.mem_sel     = mem_sel_w;
  assign bus.ir_write    = ir_write_w;
  assign bus.pc_write    = pc_write_w;
  assign bus.reg_write   = reg_write_w;
  assign bus.link_write  = link_write_w;
  assign bus.pc_src      = pc_src_w;
  assign bus.alu_op      = alu_op_w;
  assign bus.alu_src_imm = alu_src_imm_w;
  assign bus.wb_sel_mem  = wb_sel_mem_w;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire
